// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with signed/unsigned
// operands, remainder, divide-by-zero and signed-overflow flags.
module seq_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div0,
    output logic         ovf
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(W);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;

    logic [CW-1:0] count;
    logic [W-1:0]  quo_sh;
    logic [W-1:0]  dvs_mag;
    logic [W-1:0]  raw_dvd;
    logic [W:0]    part;
    logic          qneg, rneg, zero_f, ovf_f;

    logic [W-1:0]  cap_dvd, cap_dvs;
    logic          cap_zero, cap_ovf;
    logic [W+1:0]  trial;
    logic          qbit;
    logic          load, step, finish;
    logic [W-1:0]  res_q, res_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (count == COUNT_ONE) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Magnitudes are unsigned W-bit values, so the most negative operand still fits.
    always_comb begin
        cap_dvd  = (sgn && dividend[W-1]) ? -dividend : dividend;
        cap_dvs  = (sgn && divisor[W-1])  ? -divisor  : divisor;
        cap_zero = (divisor == '0);
        cap_ovf  = sgn && (dividend == MOST_NEG) && (divisor == '1);
    end

    // The partial remainder's top bit stays 0, so trial[W+1] is the borrow.
    always_comb begin
        trial = {part, quo_sh[W-1]} - {2'b00, dvs_mag};
        qbit  = ~trial[W+1];
    end

    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == CALC);
        finish = (state == FIX);
        if (zero_f) begin
            res_q = '1;
            res_r = raw_dvd;
        end else if (ovf_f) begin
            res_q = MOST_NEG;
            res_r = '0;
        end else begin
            res_q = qneg ? -quo_sh : quo_sh;
            res_r = rneg ? -part[W-1:0] : part[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            quo_sh    <= '0;
            dvs_mag   <= '0;
            raw_dvd   <= '0;
            part      <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            zero_f    <= 1'b0;
            ovf_f     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                quo_sh  <= cap_dvd;
                dvs_mag <= cap_dvs;
                raw_dvd <= dividend;
                part    <= '0;
                qneg    <= sgn & (dividend[W-1] ^ divisor[W-1]);
                rneg    <= sgn & dividend[W-1];
                zero_f  <= cap_zero;
                ovf_f   <= cap_ovf;
                count   <= COUNT_INIT;
                busy    <= 1'b1;
            end else if (step) begin
                part   <= qbit ? trial[W:0] : {part[W-1:0], quo_sh[W-1]};
                quo_sh <= {quo_sh[W-2:0], qbit};
                count  <= count - COUNT_ONE;
            end else if (finish) begin
                quotient  <= res_q;
                remainder <= res_r;
                div0      <= zero_f;
                ovf       <= ovf_f;
                busy      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at W=8, 16 and 3; a negedge monitor checks
// every done against queued hand-computed results and the expected done cycle.
module tb_seq_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        bit          z;
        bit          o;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic        clk, rst;
    logic        start_a[3], sgn_a[3];
    logic [31:0] dvd_a[3], dvs_a[3];
    logic        busy_a[3], done_a[3], z_a[3], o_a[3];
    logic [31:0] q_a[3], r_a[3];
    int          ws[3] = '{8, 16, 3};
    int unsigned cyc;
    int          compared, failed;
    exp_t        sb[3][$];
    exp_t        mon_e;

    logic        busy8, done8, z8, o8;
    logic [7:0]  q8, r8;
    logic        busy16, done16, z16, o16;
    logic [15:0] q16, r16;
    logic        busy3, done3, z3, o3;
    logic [2:0]  q3, r3;

    seq_divider #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_a[0]), .sgn(sgn_a[0]),
        .dividend(dvd_a[0][7:0]), .divisor(dvs_a[0][7:0]),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
        .div0(z8), .ovf(o8)
    );
    seq_divider #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start_a[1]), .sgn(sgn_a[1]),
        .dividend(dvd_a[1][15:0]), .divisor(dvs_a[1][15:0]),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
        .div0(z16), .ovf(o16)
    );
    seq_divider #(.W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_a[2]), .sgn(sgn_a[2]),
        .dividend(dvd_a[2][2:0]), .divisor(dvs_a[2][2:0]),
        .busy(busy3), .done(done3), .quotient(q3), .remainder(r3),
        .div0(z3), .ovf(o3)
    );

    always_comb begin
        busy_a[0] = busy8;  done_a[0] = done8;  z_a[0] = z8;  o_a[0] = o8;
        q_a[0] = 32'(q8);   r_a[0] = 32'(r8);
        busy_a[1] = busy16; done_a[1] = done16; z_a[1] = z16; o_a[1] = o16;
        q_a[1] = 32'(q16);  r_a[1] = 32'(r16);
        busy_a[2] = busy3;  done_a[2] = done3;  z_a[2] = z3;  o_a[2] = o3;
        q_a[2] = 32'(q3);   r_a[2] = 32'(r3);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expected entry for that instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_a[k]) begin
                if (sb[k].size() == 0) begin
                    check_output($sformatf("unexpected_done_w%0d", ws[k]), 32'(done_a[k]), 32'd0);
                end else begin
                    mon_e = sb[k].pop_front();
                    check_output({mon_e.name, "_quotient"}, q_a[k], mon_e.q);
                    check_output({mon_e.name, "_remainder"}, r_a[k], mon_e.r);
                    check_output({mon_e.name, "_div0"}, 32'(z_a[k]), 32'(mon_e.z));
                    check_output({mon_e.name, "_ovf"}, 32'(o_a[k]), 32'(mon_e.o));
                    check_output({mon_e.name, "_done_cycle"}, cyc, mon_e.cyc);
                    check_output({mon_e.name, "_busy_at_done"}, 32'(busy_a[k]), 32'd0);
                end
            end
        end
    end

    // Called just after a falling edge; the start is sampled on the next rising edge.
    task automatic apply_stimulus(input int k, input bit s, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] eq, input logic [31:0] er,
                                  input bit ez, input bit eo, input string name);
        exp_t e;
        e.q = eq; e.r = er; e.z = ez; e.o = eo;
        e.cyc = cyc + ws[k] + 2;
        e.name = name;
        sb[k].push_back(e);
        start_a[k] = 1'b1;
        sgn_a[k]   = s;
        dvd_a[k]   = a;
        dvs_a[k]   = b;
        @(posedge clk);
        #1;
        start_a[k] = 1'b0;
        sgn_a[k]   = 1'($urandom);
        dvd_a[k]   = $urandom;
        dvs_a[k]   = $urandom;
    endtask

    task automatic wait_done(input int k, output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done_a[k]) seen = 1'b1;
            else if (busy_a[k]) busy_cnt++;
        end
        if (!seen) check_output($sformatf("done_timeout_w%0d", ws[k]), 32'(done_a[k]), 32'd1);
    endtask

    task automatic run_div(input int k, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input bit ez, input bit eo, input string name);
        int bc;
        @(negedge clk);
        apply_stimulus(k, s, a, b, eq, er, ez, eo, name);
        wait_done(k, bc);
        check_output({name, "_busy_cycles"}, 32'(bc), 32'(ws[k] + 1));
    endtask

    task automatic check_all_zero(input int k, input string tag);
        check_output({tag, "_quotient"}, q_a[k], 32'd0);
        check_output({tag, "_remainder"}, r_a[k], 32'd0);
        check_output({tag, "_busy"}, 32'(busy_a[k]), 32'd0);
        check_output({tag, "_done"}, 32'(done_a[k]), 32'd0);
        check_output({tag, "_div0"}, 32'(z_a[k]), 32'd0);
        check_output({tag, "_ovf"}, 32'(o_a[k]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bc;
        compared = 0;
        failed   = 0;
        cyc      = 0;
        rst      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            sgn_a[k]   = 1'b0;
            dvd_a[k]   = '0;
            dvs_a[k]   = '0;
        end
        #12;
        for (int k = 0; k < 3; k++) check_all_zero(k, $sformatf("reset_w%0d", ws[k]));
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] W=8 directed divisions");
        run_div(0, 1'b0, 200, 7, 28, 4, 1'b0, 1'b0, "w8_u200_7");
        run_div(0, 1'b1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0, 1'b0, "w8_sm7_2");
        run_div(0, 1'b1, 32'h07, 32'hFE, 32'hFD, 32'h01, 1'b0, 1'b0, "w8_s7_m2");
        run_div(0, 1'b0, 32'h55, 32'h00, 32'hFF, 32'h55, 1'b1, 1'b0, "w8_u_div0");
        run_div(0, 1'b1, 32'h55, 32'h00, 32'hFF, 32'h55, 1'b1, 1'b0, "w8_s_div0");
        run_div(0, 1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 1'b1, "w8_ovf");
        run_div(0, 1'b1, 32'h80, 32'h03, 32'hD6, 32'hFE, 1'b0, 1'b0, "w8_sm128_3");
        run_div(0, 1'b0, 255, 1, 255, 0, 1'b0, 1'b0, "w8_u255_1");

        $display("[TB] W=8 start while busy");
        @(negedge clk);
        apply_stimulus(0, 1'b0, 100, 9, 11, 1, 1'b0, 1'b0, "w8_ignore");
        repeat (2) @(negedge clk);
        start_a[0] = 1'b1;
        sgn_a[0]   = 1'b1;
        dvd_a[0]   = 50;
        dvs_a[0]   = 5;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        wait_done(0, bc);

        $display("[TB] W=8 start in done cycle");
        run_div(0, 1'b0, 99, 10, 9, 9, 1'b0, 1'b0, "w8_b2b_first");
        apply_stimulus(0, 1'b0, 250, 16, 15, 10, 1'b0, 1'b0, "w8_b2b_second");
        wait_done(0, bc);
        check_output("w8_b2b_second_busy_cycles", 32'(bc), 32'(ws[0] + 1));

        $display("[TB] W=8 reset mid-division");
        @(negedge clk);
        apply_stimulus(0, 1'b0, 123, 5, 24, 3, 1'b0, 1'b0, "w8_aborted");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero(0, "midreset_w8");
        sb[0].delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        run_div(0, 1'b0, 15, 4, 3, 3, 1'b0, 1'b0, "w8_after_reset");

        $display("[TB] W=16 directed divisions");
        run_div(1, 1'b0, 50000, 7, 7142, 6, 1'b0, 1'b0, "w16_u50000_7");
        run_div(1, 1'b1, 64536, 7, 65394, 65530, 1'b0, 1'b0, "w16_sm1000_7");
        run_div(1, 1'b1, 1000, 65529, 65394, 6, 1'b0, 1'b0, "w16_s1000_m7");
        run_div(1, 1'b1, 32'h1234, 0, 32'hFFFF, 32'h1234, 1'b1, 1'b0, "w16_div0");
        run_div(1, 1'b1, 32'h8000, 32'hFFFF, 32'h8000, 0, 1'b0, 1'b1, "w16_ovf");

        $display("[TB] W=3 directed divisions");
        run_div(2, 1'b0, 7, 2, 3, 1, 1'b0, 1'b0, "w3_u7_2");
        run_div(2, 1'b1, 5, 2, 7, 7, 1'b0, 1'b0, "w3_sm3_2");
        run_div(2, 1'b1, 3, 6, 7, 1, 1'b0, 1'b0, "w3_s3_m2");
        run_div(2, 1'b1, 4, 7, 4, 0, 1'b0, 1'b1, "w3_ovf");
        run_div(2, 1'b0, 5, 0, 7, 5, 1'b1, 1'b0, "w3_div0");

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check_output($sformatf("pending_results_w%0d", ws[k]), 32'(sb[k].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
